// File: rtl/click_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// click_cmd_sequencer
//
// Board-level test sequencer sitting between the double-click button detector
// and the SDRAM controller.
//   * Single click  -> write the next pattern word into SDRAM.
//   * Double click  -> read back the oldest unread word and show it on LEDs.
//   * Between commands the detector is re-armed by pulsing its active-low reset.
//   * Write/read pointers form a circular queue so reads never pass writes.
//
// Optional feature macro: CLICK_SEQ_TIMEOUT_EN
//   When defined, a watchdog counter runs in ACK, DONE and RDWAIT. If it hits
//   TIMEOUT cycles in one of those states the command is abandoned, the sticky
//   err flag is set and the sequencer re-arms. When undefined, those states wait
//   indefinitely and err is tied low.
//
// Parameters
//   ADDR_W      SDRAM word-address width, also pointer width
//   DATA_W      SDRAM data width
//   ARM_CYCLES  cycles det_rst_n is held low per re-arm (>= 1)
//   TIMEOUT     watchdog limit in cycles (watchdog build only)
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   det_single  detector single-click result (level, held until re-arm)
//   det_double  detector double-click result (level, held until re-arm)
//   det_rst_n   detector reset, active-low; 0 = re-arm
//   wr_addr     SDRAM write address
//   wr_data     SDRAM write data
//   wr_enable   SDRAM write request, 1-cycle pulse
//   rd_addr     SDRAM read address
//   rd_enable   SDRAM read request, 1-cycle pulse
//   rd_data     SDRAM read data, valid with rd_ready
//   rd_ready    SDRAM read data strobe
//   busy        SDRAM controller busy
//   led_data    last word read back
//   idle        1 only while waiting for a click
//   err         sticky watchdog error
// -----------------------------------------------------------------------------
module click_cmd_sequencer #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ARM_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              det_single,
  input  logic              det_double,
  output logic              det_rst_n,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  input  logic              busy,
  output logic [DATA_W-1:0] led_data,
  output logic              idle,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_ARM,
    ST_WAIT,
    ST_ISSUE,
    ST_ACK,
    ST_DONE,
    ST_RDWAIT
  } state_t;

  // Re-arm counter sized so ARM_CYCLES = 1 still gets a legal 1-bit counter.
  localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  // Pattern data is the write pointer XOR alternating 1010... bits. The pointer
  // is zero-extended first so narrow address builds still produce DATA_W bits.
  localparam int unsigned WIDE = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [DATA_W-1:0] PATTERN = DATA_W'({(DATA_W / 2){2'b10}});

  state_t            state;
  logic [ARM_W-1:0]  arm_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              op_read;     // latched command type for the current transaction

  logic [WIDE-1:0]   wr_ptr_ext;
  logic [DATA_W-1:0] next_wr_data;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W-1:0] rd_ptr_inc;
  logic              queue_empty;
  logic              queue_full;

  assign wr_ptr_ext   = WIDE'(wr_ptr);
  assign next_wr_data = wr_ptr_ext[DATA_W-1:0] ^ PATTERN;
  assign wr_ptr_inc   = wr_ptr + ADDR_W'(1);
  assign rd_ptr_inc   = rd_ptr + ADDR_W'(1);

  // One slot is always left unused so that full and empty are distinguishable
  // purely from the pointers; comparisons wrap modulo 2^ADDR_W.
  assign queue_empty  = (rd_ptr == wr_ptr);
  assign queue_full   = (wr_ptr_inc == rd_ptr);

`ifdef CLICK_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // Cleared on entry to each watched state; reaching TO_LAST means the state
  // has already been occupied for TIMEOUT cycles.
  logic [TO_W-1:0] to_cnt;
`else
  assign err = 1'b0;
`endif

  // NOTE: every register below is assigned with non-blocking (<=) inside a
  // single clocked block, and reset is sampled on the clock edge (synchronous),
  // so all state updates see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARM;
      arm_cnt   <= '0;
      det_rst_n <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      led_data  <= '0;
      idle      <= 1'b0;
      op_read   <= 1'b0;
`ifdef CLICK_SEQ_TIMEOUT_EN
      to_cnt    <= '0;
      err       <= 1'b0;
`endif
    end else begin
      // Request strobes are single-cycle; only ISSUE raises them.
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;

      case (state)
        // Hold the detector in reset for exactly ARM_CYCLES cycles.
        ST_ARM: begin
          if (arm_cnt == ARM_LAST) begin
            arm_cnt   <= '0;
            det_rst_n <= 1'b1;
            idle      <= 1'b1;
            state     <= ST_WAIT;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end

        // A double click wins over a single click if both are reported.
        // Refused commands (empty read, full write) just re-arm the detector.
        ST_WAIT: begin
          if (det_double) begin
            op_read <= 1'b1;
            if (queue_empty) begin
              det_rst_n <= 1'b0;
              idle      <= 1'b0;
              state     <= ST_ARM;
            end else begin
              rd_addr <= rd_ptr;
              idle    <= 1'b0;
              state   <= ST_ISSUE;
            end
          end else if (det_single) begin
            op_read <= 1'b0;
            if (queue_full) begin
              det_rst_n <= 1'b0;
              idle      <= 1'b0;
              state     <= ST_ARM;
            end else begin
              wr_addr <= wr_ptr;
              wr_data <= next_wr_data;
              idle    <= 1'b0;
              state   <= ST_ISSUE;
            end
          end
        end

        // Address/data were captured on leaving WAIT and stay put until the
        // next command, so the controller may sample them at any point.
        ST_ISSUE: begin
          if (!busy) begin
            if (op_read) begin
              rd_enable <= 1'b1;
            end else begin
              wr_enable <= 1'b1;
            end
            state <= ST_ACK;
`ifdef CLICK_SEQ_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end

        // The controller signals acceptance by raising busy.
        ST_ACK: begin
          if (busy) begin
            state <= ST_DONE;
`ifdef CLICK_SEQ_TIMEOUT_EN
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            err       <= 1'b1;
            det_rst_n <= 1'b0;
            state     <= ST_ARM;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
`endif
          end
        end

        // Writes complete when busy drops; reads go straight on to wait for data.
        ST_DONE: begin
          if (op_read) begin
            state <= ST_RDWAIT;
`ifdef CLICK_SEQ_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else if (!busy) begin
            wr_ptr    <= wr_ptr_inc;
            det_rst_n <= 1'b0;
            state     <= ST_ARM;
`ifdef CLICK_SEQ_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            err       <= 1'b1;
            det_rst_n <= 1'b0;
            state     <= ST_ARM;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
`endif
          end
        end

        // Only the first strobe here is consumed; strobes elsewhere are ignored.
        ST_RDWAIT: begin
          if (rd_ready) begin
            led_data  <= rd_data;
            rd_ptr    <= rd_ptr_inc;
            det_rst_n <= 1'b0;
            state     <= ST_ARM;
`ifdef CLICK_SEQ_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            err       <= 1'b1;
            det_rst_n <= 1'b0;
            state     <= ST_ARM;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
`endif
          end
        end

        default: begin
          det_rst_n <= 1'b0;
          idle      <= 1'b0;
          arm_cnt   <= '0;
          state     <= ST_ARM;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  a_params_sane: assert property (@(posedge clk)
    (ARM_CYCLES >= 1) && (TIMEOUT >= 1));

  a_one_request: assert property (@(posedge clk) disable iff (rst)
    !(wr_enable && rd_enable));

  a_wr_pulse: assert property (@(posedge clk) disable iff (rst)
    wr_enable |=> !wr_enable);

  a_rd_pulse: assert property (@(posedge clk) disable iff (rst)
    rd_enable |=> !rd_enable);

  a_idle_armed: assert property (@(posedge clk) disable iff (rst)
    idle |-> det_rst_n);

endmodule

// File: tb/tb_click_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_click_cmd_sequencer
//
// Directed bench for click_cmd_sequencer. A narrow 3-bit address build is used
// so the full/wrap boundary of the pointer queue can be reached quickly.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_click_cmd_sequencer;

  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 16;
  localparam int ARM_CYCLES = 4;
  localparam int TIMEOUT    = 15;
  localparam int LIMIT      = 200;
  localparam logic [DATA_W-1:0] PAT = 16'hAAAA;

  logic              clk = 1'b0;
  logic              rst;
  logic              det_single;
  logic              det_double;
  logic              det_rst_n;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_enable;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;
  logic [DATA_W-1:0] led_data;
  logic              idle;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  click_cmd_sequencer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ARM_CYCLES(ARM_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .det_single(det_single),
    .det_double(det_double),
    .det_rst_n (det_rst_n),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .rd_addr   (rd_addr),
    .rd_enable (rd_enable),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .led_data  (led_data),
    .idle      (idle),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only; comparisons live in the test tasks)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    det_single = 1'b0;
    det_double = 1'b0;
    busy       = 1'b0;
    rd_ready   = 1'b0;
    rd_data    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      if (idle === 1'b1 && det_rst_n === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_pulse(output bit got_wr, output bit got_rd, output int cyc);
    got_wr = 1'b0;
    got_rd = 1'b0;
    cyc    = 0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      cyc = i + 1;
      if (wr_enable === 1'b1 || rd_enable === 1'b1) begin
        got_wr = (wr_enable === 1'b1);
        got_rd = (rd_enable === 1'b1);
        return;
      end
    end
  endtask

  // Controller model: accept the command with a one-cycle busy pulse.
  task automatic accept_cmd();
    busy = 1'b1;
    tick();
    busy       = 1'b0;
    det_single = 1'b0;
    det_double = 1'b0;
    tick();
  endtask

  task automatic deliver_read(input logic [DATA_W-1:0] data);
    rd_data  = data;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rd_data  = '0;
  endtask

  task automatic do_write(output bit got, output logic [ADDR_W-1:0] a,
                          output logic [DATA_W-1:0] d);
    bit ok, gw, gr;
    int cyc;
    got = 1'b0;
    a   = '0;
    d   = '0;
    wait_idle(ok);
    if (!ok) return;
    det_single = 1'b1;
    wait_pulse(gw, gr, cyc);
    got = gw && !gr;
    a   = wr_addr;
    d   = wr_data;
    accept_cmd();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst        = 1'b1;
    det_single = 1'b1;
    det_double = 1'b1;
    busy       = 1'b0;
    rd_ready   = 1'b1;
    rd_data    = 16'hFFFF;
    tick();
    tick();
    checks++; if (det_rst_n !== 1'b0) begin errors++; $display("FAIL reset_det_rst_n got %b expected 0", det_rst_n); end
    checks++; if (wr_enable !== 1'b0 || rd_enable !== 1'b0) begin errors++; $display("FAIL reset_enables got wr=%b rd=%b expected 0/0", wr_enable, rd_enable); end
    checks++; if (led_data !== 16'h0000) begin errors++; $display("FAIL reset_led got %h expected 0000", led_data); end
    checks++; if (idle !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_idle_err got idle=%b err=%b expected 0/0", idle, err); end
    checks++; if (dut.wr_ptr !== 3'd0 || dut.rd_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptrs got wr=%0d rd=%0d expected 0/0", dut.wr_ptr, dut.rd_ptr); end
    det_single = 1'b0;
    det_double = 1'b0;
    rd_ready   = 1'b0;
    rd_data    = '0;
    rst        = 1'b0;
  endtask

  task automatic test_first_write();
    int low;
    rst        = 1'b1;
    det_single = 1'b1;
    det_double = 1'b0;
    busy       = 1'b0;
    rd_ready   = 1'b0;
    tick();
    rst = 1'b0;
    low = 0;
    for (int i = 0; i < 20 && det_rst_n !== 1'b1; i++) begin
      low++;
      tick();
    end
    checks++; if (low != ARM_CYCLES) begin errors++; $display("FAIL arm_low_cycles got %0d expected %0d", low, ARM_CYCLES); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL wait_idle got %b expected 1", idle); end
    tick();
    checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL early_wr_enable got %b expected 0", wr_enable); end
    tick();
    checks++; if (wr_enable !== 1'b1 || rd_enable !== 1'b0) begin errors++; $display("FAIL first_pulse got wr=%b rd=%b expected 1/0", wr_enable, rd_enable); end
    checks++; if (wr_addr !== 3'd0 || wr_data !== 16'hAAAA) begin errors++; $display("FAIL first_addr_data got %0d/%h expected 0/aaaa", wr_addr, wr_data); end
    tick();
    checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL pulse_width got %b expected 0", wr_enable); end
    busy = 1'b1;
    tick();
    busy       = 1'b0;
    det_single = 1'b0;
    tick();
    checks++; if (dut.wr_ptr !== 3'd1) begin errors++; $display("FAIL first_wr_ptr got %0d expected 1", dut.wr_ptr); end
    checks++; if (det_rst_n !== 1'b0) begin errors++; $display("FAIL rearm got %b expected 0", det_rst_n); end
  endtask

  task automatic test_write_read();
    bit got, ok, gw, gr;
    int cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      do_write(got, a, d);
      checks++; if (!got || a !== ADDR_W'(k) || d !== (PAT ^ DATA_W'(k))) begin errors++; $display("FAIL wr%0d got pulse=%b addr=%0d data=%h expected 1/%0d/%h", k, got, a, d, k, PAT ^ DATA_W'(k)); end
    end
    wait_idle(ok);
    det_double = 1'b1;
    wait_pulse(gw, gr, cyc);
    checks++; if (!gr || gw || cyc != 2) begin errors++; $display("FAIL rd_pulse got rd=%b wr=%b latency=%0d expected 1/0/2", gr, gw, cyc); end
    checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL rd_addr got %0d expected 0", rd_addr); end
    accept_cmd();
    deliver_read(16'h1234);
    checks++; if (led_data !== 16'h1234) begin errors++; $display("FAIL rd_led got %h expected 1234", led_data); end
    checks++; if (dut.rd_ptr !== 3'd1 || dut.wr_ptr !== 3'd3) begin errors++; $display("FAIL rd_ptrs got rd=%0d wr=%0d expected 1/3", dut.rd_ptr, dut.wr_ptr); end
    checks++; if (det_rst_n !== 1'b0) begin errors++; $display("FAIL rd_rearm got %b expected 0", det_rst_n); end
  endtask

  task automatic test_empty_read();
    bit ok;
    int seen;
    apply_reset();
    // Stray strobe outside RDWAIT must not reach the LEDs.
    rd_data  = 16'hBEEF;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rd_data  = '0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_wait_idle got timeout expected idle"); end
    det_double = 1'b1;
    tick();
    checks++; if (det_rst_n !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL empty_rearm got det_rst_n=%b idle=%b expected 0/0", det_rst_n, idle); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_enable === 1'b1 || wr_enable === 1'b1) seen++;
      tick();
    end
    det_double = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL empty_no_cmd got %0d pulses expected 0", seen); end
    checks++; if (led_data !== 16'h0000 || dut.rd_ptr !== 3'd0) begin errors++; $display("FAIL empty_state got led=%h rd=%0d expected 0000/0", led_data, dut.rd_ptr); end
  endtask

  task automatic test_busy_hold();
    bit ok, gw, gr;
    int cyc, n;
    apply_reset();
    wait_idle(ok);
    busy       = 1'b1;
    det_single = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_enable === 1'b1 || rd_enable === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL busy_hold got %0d pulses expected 0", n); end
    busy = 1'b0;
    wait_pulse(gw, gr, cyc);
    checks++; if (!gw || gr || cyc != 1) begin errors++; $display("FAIL busy_release got wr=%b rd=%b cyc=%0d expected 1/0/1", gw, gr, cyc); end
    tick();
    checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL busy_single got %b expected 0", wr_enable); end
    accept_cmd();
    checks++; if (dut.wr_ptr !== 3'd1) begin errors++; $display("FAIL busy_wr_ptr got %0d expected 1", dut.wr_ptr); end
  endtask

  task automatic test_both_clicks();
    bit got, ok, gw, gr;
    int cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    apply_reset();
    do_write(got, a, d);
    wait_idle(ok);
    det_single = 1'b1;
    det_double = 1'b1;
    wait_pulse(gw, gr, cyc);
    checks++; if (!gr || gw) begin errors++; $display("FAIL both_priority got rd=%b wr=%b expected 1/0", gr, gw); end
    checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL both_rd_addr got %0d expected 0", rd_addr); end
    accept_cmd();
    deliver_read(16'h5A5A);
    checks++; if (led_data !== 16'h5A5A || dut.wr_ptr !== 3'd1) begin errors++; $display("FAIL both_result got led=%h wr=%0d expected 5a5a/1", led_data, dut.wr_ptr); end
  endtask

  task automatic test_full_wrap();
    bit got, ok, gw, gr;
    int cyc, seen;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      do_write(got, a, d);
      checks++; if (!got || a !== ADDR_W'(k)) begin errors++; $display("FAIL fill%0d got pulse=%b addr=%0d expected 1/%0d", k, got, a, k); end
    end
    wait_idle(ok);
    det_single = 1'b1;
    tick();
    checks++; if (det_rst_n !== 1'b0) begin errors++; $display("FAIL full_rearm got %b expected 0", det_rst_n); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr_enable === 1'b1 || rd_enable === 1'b1) seen++;
      tick();
    end
    det_single = 1'b0;
    checks++; if (seen != 0 || dut.wr_ptr !== 3'd7) begin errors++; $display("FAIL full_refuse got pulses=%0d wr=%0d expected 0/7", seen, dut.wr_ptr); end
    wait_idle(ok);
    det_double = 1'b1;
    wait_pulse(gw, gr, cyc);
    checks++; if (!gr || rd_addr !== 3'd0) begin errors++; $display("FAIL full_read got rd=%b addr=%0d expected 1/0", gr, rd_addr); end
    accept_cmd();
    deliver_read(16'h0F0F);
    checks++; if (led_data !== 16'h0F0F) begin errors++; $display("FAIL full_led got %h expected 0f0f", led_data); end
    do_write(got, a, d);
    checks++; if (!got || a !== 3'd7 || d !== 16'hAAAD) begin errors++; $display("FAIL wrap_write got pulse=%b addr=%0d data=%h expected 1/7/aaad", got, a, d); end
    checks++; if (dut.wr_ptr !== 3'd0) begin errors++; $display("FAIL wrap_ptr got %0d expected 0", dut.wr_ptr); end
  endtask

  task automatic test_reset_rdwait();
    bit got, ok, gw, gr;
    int cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    apply_reset();
    do_write(got, a, d);
    wait_idle(ok);
    det_double = 1'b1;
    wait_pulse(gw, gr, cyc);
    busy = 1'b1;
    tick();
    busy       = 1'b0;
    det_double = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (det_rst_n !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL rdwait_rst got det_rst_n=%b idle=%b expected 0/0", det_rst_n, idle); end
    checks++; if (dut.wr_ptr !== 3'd0 || dut.rd_ptr !== 3'd0) begin errors++; $display("FAIL rdwait_ptrs got wr=%0d rd=%0d expected 0/0", dut.wr_ptr, dut.rd_ptr); end
    deliver_read(16'h7777);
    checks++; if (led_data !== 16'h0000) begin errors++; $display("FAIL rdwait_abandon got %h expected 0000", led_data); end
  endtask

`ifdef CLICK_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit got, ok, gw, gr;
    int cyc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    apply_reset();
    wait_idle(ok);
    det_single = 1'b1;
    wait_pulse(gw, gr, cyc);
    det_single = 1'b0;
    checks++; if (!gw) begin errors++; $display("FAIL to_pulse got %b expected 1", gw); end
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_early got %b expected 0", err); end
    tick();
    checks++; if (err !== 1'b1 || det_rst_n !== 1'b0 || dut.wr_ptr !== 3'd0) begin errors++; $display("FAIL to_fire got err=%b det_rst_n=%b wr=%0d expected 1/0/0", err, det_rst_n, dut.wr_ptr); end
    do_write(got, a, d);
    checks++; if (!got || a !== 3'd0 || dut.wr_ptr !== 3'd1 || err !== 1'b1) begin errors++; $display("FAIL to_recover got pulse=%b addr=%0d wr=%0d err=%b expected 1/0/1/1", got, a, dut.wr_ptr, err); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    det_single = 1'b0;
    det_double = 1'b0;
    busy       = 1'b0;
    rd_ready   = 1'b0;
    rd_data    = '0;
    test_reset();
    test_first_write();
    test_write_read();
    test_empty_read();
    test_busy_hold();
    test_both_clicks();
    test_full_wrap();
    test_reset_rdwait();
`ifdef CLICK_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
